uart_txrx: RTL and testbench

UART_TXRX -- requirements
Module: uart_txrx

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_txrx_if.sv | 28 ++
 rtl/uart_rx.sv | 90 +++++++++
 rtl/uart_tx.sv | 82 ++++++++
 rtl/uart_txrx.sv | 44 ++++
 tb/tb_uart_txrx.sv | 266 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and the parity rule used by both
// the transmitter and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // Zero-extension to 64 bits leaves the XOR unchanged, so any word width fits.
    function automatic logic parity_bit(input logic [63:0] data, input logic even_par);
        return even_par ? ^data : ~(^data);
    endfunction

endpackage

// File: rtl/uart_txrx_if.sv
// Bundle of the serial lines and word-level handshake signals of one UART.
interface uart_txrx_if #(
    parameter int PACK_SIZE = 8
);
    logic                 rx_bit;
    logic                 rx_byte_valid;
    logic [PACK_SIZE-1:0] rx_byte_data;
    logic                 rx_active;
    logic                 par_error;
    logic                 stop_error;
    logic                 tx_byte_valid;
    logic [PACK_SIZE-1:0] tx_byte_data;
    logic                 tx_bit;
    logic                 tx_active;
    logic                 tx_done;

    modport master (
        output rx_bit, tx_byte_valid, tx_byte_data,
        input  rx_byte_valid, rx_byte_data, rx_active, par_error, stop_error,
        input  tx_bit, tx_active, tx_done
    );

    modport slave (
        input  rx_bit, tx_byte_valid, tx_byte_data,
        output rx_byte_valid, rx_byte_data, rx_active, par_error, stop_error,
        output tx_bit, tx_active, tx_done
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: two-flop synchroniser, half-bit start qualification, then one
// mid-bit sample per bit; results and error flags update at the stop-bit sample.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 868,
    parameter int PACK_SIZE   = 8,
    parameter int PARITY_EN   = 0,
    parameter int EVEN_PAR    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_bit,
    output logic                 rx_byte_valid,
    output logic [PACK_SIZE-1:0] rx_byte_data,
    output logic                 rx_active,
    output logic                 par_error,
    output logic                 stop_error
);
    localparam int TW = $clog2(CLK_PER_BIT);
    localparam int IW = $clog2(PACK_SIZE + 1);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLK_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLK_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(PACK_SIZE - 1);

    uart_state_t          state;
    logic [1:0]           sync;
    logic [TW-1:0]        timer;
    logic [IW-1:0]        bit_idx;
    logic [PACK_SIZE-1:0] shreg;
    logic                 par_sample;
    logic                 rx_s;
    logic                 bit_end;

    assign rx_s      = sync[1];
    assign rx_active = (state != IDLE);
    assign bit_end   = (state == START) ? (timer == HALF_LAST) : (timer == BIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync          <= 2'b11;
            state         <= IDLE;
            timer         <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            par_sample    <= 1'b0;
            rx_byte_valid <= 1'b0;
            rx_byte_data  <= '0;
            par_error     <= 1'b0;
            stop_error    <= 1'b0;
        end else begin
            sync          <= {sync[0], rx_bit};
            rx_byte_valid <= 1'b0;
            if (state == IDLE) begin
                timer   <= '0;
                bit_idx <= '0;
                if (!rx_s)
                    state <= START;
            end else if (!bit_end) begin
                timer <= timer + 1'b1;
            end else begin
                timer <= '0;
                case (state)
                    // A start bit that is high again at mid-bit is treated as noise.
                    START: state <= rx_s ? IDLE : DATA;
                    DATA: begin
                        shreg   <= {rx_s, shreg[PACK_SIZE-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == IDX_LAST)
                            state <= (PARITY_EN != 0) ? PARITY : STOP;
                    end
                    PARITY: begin
                        par_sample <= rx_s;
                        state      <= STOP;
                    end
                    STOP: begin
                        rx_byte_data  <= shreg;
                        stop_error    <= ~rx_s;
                        par_error     <= (PARITY_EN != 0) &&
                                         (par_sample != parity_bit(64'(shreg), EVEN_PAR != 0));
                        rx_byte_valid <= 1'b1;
                        state         <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: serialises one latched word into start, data, optional parity
// and stop bits, each held for CLK_PER_BIT cycles.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 868,
    parameter int PACK_SIZE   = 8,
    parameter int PARITY_EN   = 0,
    parameter int EVEN_PAR    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_byte_valid,
    input  logic [PACK_SIZE-1:0] tx_byte_data,
    output logic                 tx_bit,
    output logic                 tx_active,
    output logic                 tx_done
);
    localparam int TW = $clog2(CLK_PER_BIT);
    localparam int IW = $clog2(PACK_SIZE + 1);
    localparam logic [TW-1:0] BIT_LAST = TW'(CLK_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(PACK_SIZE - 1);

    uart_state_t          state;
    logic [TW-1:0]        timer;
    logic [IW-1:0]        bit_idx;
    logic [PACK_SIZE-1:0] shreg;
    logic                 par;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par     <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (state == IDLE) begin
                timer   <= '0;
                bit_idx <= '0;
                if (tx_byte_valid) begin
                    shreg <= tx_byte_data;
                    par   <= parity_bit(64'(tx_byte_data), EVEN_PAR != 0);
                    state <= START;
                end
            end else if (timer != BIT_LAST) begin
                timer <= timer + 1'b1;
            end else begin
                timer <= '0;
                case (state)
                    START: state <= DATA;
                    DATA: begin
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == IDX_LAST)
                            state <= (PARITY_EN != 0) ? PARITY : STOP;
                    end
                    PARITY: state <= STOP;
                    STOP: begin
                        state   <= IDLE;
                        tx_done <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Line level follows the state directly, so reset forces the idle level at once.
    always_comb begin
        tx_active = (state != IDLE);
        case (state)
            START:   tx_bit = 1'b0;
            DATA:    tx_bit = shreg[0];
            PARITY:  tx_bit = par;
            default: tx_bit = 1'b1;
        endcase
    end

endmodule

// File: rtl/uart_txrx.sv
// Full-duplex UART: independent receiver and transmitter sharing only clock and reset.
module uart_txrx #(
    parameter int CLK_PER_BIT = 868,
    parameter int PACK_SIZE   = 8,
    parameter int PARITY_EN   = 0,
    parameter int EVEN_PAR    = 0
) (
    input logic     clk,
    input logic     rst,
    uart_txrx_if.slave bus
);

    uart_rx #(
        .CLK_PER_BIT(CLK_PER_BIT),
        .PACK_SIZE  (PACK_SIZE),
        .PARITY_EN  (PARITY_EN),
        .EVEN_PAR   (EVEN_PAR)
    ) u_rx (
        .clk          (clk),
        .rst          (rst),
        .rx_bit       (bus.rx_bit),
        .rx_byte_valid(bus.rx_byte_valid),
        .rx_byte_data (bus.rx_byte_data),
        .rx_active    (bus.rx_active),
        .par_error    (bus.par_error),
        .stop_error   (bus.stop_error)
    );

    uart_tx #(
        .CLK_PER_BIT(CLK_PER_BIT),
        .PACK_SIZE  (PACK_SIZE),
        .PARITY_EN  (PARITY_EN),
        .EVEN_PAR   (EVEN_PAR)
    ) u_tx (
        .clk          (clk),
        .rst          (rst),
        .tx_byte_valid(bus.tx_byte_valid),
        .tx_byte_data (bus.tx_byte_data),
        .tx_bit       (bus.tx_bit),
        .tx_active    (bus.tx_active),
        .tx_done      (bus.tx_done)
    );

endmodule

// File: tb/tb_uart_txrx.sv
// Scoreboard bench: two UART instances (odd parity / no parity) driven with random and
// directed frames; a single monitor process compares every output event with queued expectations.
module tb_uart_txrx;
    localparam int CPB = 10;

    typedef struct packed {
        logic [7:0] data;
        logic       pe;
        logic       se;
    } rx_exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_txrx_if #(.PACK_SIZE(8)) bus_p ();
    uart_txrx_if #(.PACK_SIZE(8)) bus_n ();

    uart_txrx #(.CLK_PER_BIT(CPB), .PACK_SIZE(8), .PARITY_EN(1), .EVEN_PAR(0))
        dut_p (.clk(clk), .rst(rst), .bus(bus_p));
    uart_txrx #(.CLK_PER_BIT(CPB), .PACK_SIZE(8), .PARITY_EN(0), .EVEN_PAR(0))
        dut_n (.clk(clk), .rst(rst), .bus(bus_n));

    logic [1:0] loop, drv, tv;
    logic [7:0] td [2];
    assign bus_p.rx_bit        = loop[0] ? bus_p.tx_bit : drv[0];
    assign bus_n.rx_bit        = loop[1] ? bus_n.tx_bit : drv[1];
    assign bus_p.tx_byte_valid = tv[0];
    assign bus_n.tx_byte_valid = tv[1];
    assign bus_p.tx_byte_data  = td[0];
    assign bus_n.tx_byte_data  = td[1];

    logic [1:0] rxv, rxa, pe, se, txb, txa, txd;
    logic [7:0] rxd [2];
    assign rxv = {bus_n.rx_byte_valid, bus_p.rx_byte_valid};
    assign rxa = {bus_n.rx_active, bus_p.rx_active};
    assign pe  = {bus_n.par_error, bus_p.par_error};
    assign se  = {bus_n.stop_error, bus_p.stop_error};
    assign txb = {bus_n.tx_bit, bus_p.tx_bit};
    assign txa = {bus_n.tx_active, bus_p.tx_active};
    assign txd = {bus_n.tx_done, bus_p.tx_done};
    assign rxd[0] = bus_p.rx_byte_data;
    assign rxd[1] = bus_n.rx_byte_data;

    rx_exp_t    rxq0[$], rxq1[$];
    logic [7:0] txq0[$], txq1[$];
    int checks = 0, failures = 0, tmo = 0;
    int probe_req = 0, probe_ack = 0;

    // Reference rules: odd parity makes the total count of ones odd; frame = 0, data LSB first, [parity], stop.
    function automatic logic odd_parity(input logic [7:0] w);
        return ($countones(w) % 2) == 0;
    endfunction

    function automatic void build_frame(input logic [7:0] w, input logic has_par, input logic pbit,
                                        input logic sbit, output logic [15:0] bits, output int n);
        bits = 16'hFFFF;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = w[i];
        n = has_par ? 11 : 10;
        if (has_par) bits[9] = pbit;
        bits[n-1] = sbit;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic push_rx(input int d, input logic [7:0] w, input logic p, input logic s);
        rx_exp_t e;
        e = {w, p, s};
        if (d == 0) rxq0.push_back(e); else rxq1.push_back(e);
    endtask

    task automatic wait_done(input int d);
        int k;
        for (k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            if (txd[d]) break;
        end
        if (k == 400) tmo++;
    endtask

    task automatic send(input int d, input logic [7:0] w);
        if (d == 0) txq0.push_back(w); else txq1.push_back(w);
        if (loop[d]) push_rx(d, w, 1'b0, 1'b0);
        tv[d] = 1'b1; td[d] = w;
        @(posedge clk); #1;
        tv[d] = 1'b0; td[d] = 8'($urandom);
        wait_done(d);
    endtask

    task automatic rx_frame(input int d, input logic [7:0] w, input logic pbit, input logic sbit);
        logic [15:0] bits;
        int n;
        build_frame(w, d == 0, pbit, sbit, bits, n);
        push_rx(d, w, (d == 0) ? (pbit != odd_parity(w)) : 1'b0, ~sbit);
        for (int i = 0; i < n; i++) begin
            drv[d] = bits[i];
            repeat (CPB) @(posedge clk);
        end
        drv[d] = 1'b1;
        repeat (2 * CPB) @(posedge clk);
    endtask

    task automatic do_probe(input int k);
        probe_req = k;
        for (int i = 0; i < 5 && probe_ack != k; i++) @(negedge clk);
    endtask

    // Stimulus
    initial begin
        logic [7:0] w;
        int d;
        rst = 1'b1; loop = 2'b11; drv = 2'b11; tv = 2'b00; td[0] = 8'h00; td[1] = 8'h00;
        repeat (3) @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk); #1;

        send(0, 8'hFE);

        txq1.push_back(8'h00); txq1.push_back(8'hFF); txq1.push_back(8'hA5);
        push_rx(1, 8'h00, 1'b0, 1'b0); push_rx(1, 8'hFF, 1'b0, 1'b0); push_rx(1, 8'hA5, 1'b0, 1'b0);
        tv[1] = 1'b1; td[1] = 8'h00;
        @(posedge clk); #1 td[1] = 8'hFF;
        wait_done(1);
        @(posedge clk); #1 td[1] = 8'hA5;
        wait_done(1);
        @(posedge clk); #1 tv[1] = 1'b0; td[1] = 8'h00;
        wait_done(1);

        for (int i = 0; i < 6; i++) begin
            send(0, 8'($urandom));
            send(1, 8'($urandom));
        end

        loop = 2'b00;
        repeat (CPB) @(posedge clk);
        rx_frame(0, 8'h01, 1'b1, 1'b1);
        rx_frame(0, 8'h55, odd_parity(8'h55), 1'b0);
        rx_frame(1, 8'h55, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            d = int'($urandom_range(0, 1));
            w = 8'($urandom);
            rx_frame(d, w, 1'($urandom), ($urandom_range(0, 3) != 0));
        end

        do_probe(1);
        drv[1] = 1'b0;
        repeat (3) @(posedge clk);
        drv[1] = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        do_probe(2);

        loop = 2'b11;
        @(posedge clk); #1;
        txq0.push_back(8'h3C);
        tv[0] = 1'b1; td[0] = 8'h3C;
        @(posedge clk); #1 tv[0] = 1'b0;
        repeat (35) @(posedge clk); #1 rst = 1'b1;
        repeat (3) @(posedge clk); #1 rst = 1'b0;
        repeat (2 * CPB) @(posedge clk); #1;
        send(0, 8'h96);
        repeat (2 * CPB) @(posedge clk);
        do_probe(3);
    end

    // Monitor and scoreboard
    initial begin
        int cyc = 0, off;
        int tx_start [2];
        logic in_frame [2];
        logic [15:0] tx_bits [2];
        int tx_n [2];
        int act_cycles [2];
        logic [7:0] tw;
        rx_exp_t e;
        logic have;
        for (int d = 0; d < 2; d++) begin
            in_frame[d] = 1'b0; act_cycles[d] = 0; tx_start[d] = 0; tx_n[d] = 0; tx_bits[d] = '1;
        end
        forever begin
            @(negedge clk);
            cyc++;
            if (cyc > 20000) begin
                check("global_timeout", 32'(cyc), 32'd20000);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
            if (rst) begin
                for (int d = 0; d < 2; d++) begin
                    check($sformatf("reset_outputs%0d", d),
                          {txb[d], txa[d], txd[d], rxv[d], rxa[d], pe[d], se[d], rxd[d]},
                          {1'b1, 14'b0});
                    in_frame[d] = 1'b0;
                    act_cycles[d] = 0;
                end
            end else begin
                for (int d = 0; d < 2; d++) begin
                    if (txd[d]) begin
                        check($sformatf("tx_done_in_frame%0d", d), in_frame[d], 1);
                        if (in_frame[d]) begin
                            check($sformatf("tx_frame_len%0d", d), cyc - tx_start[d], tx_n[d] * CPB);
                            check($sformatf("tx_idle_at_done%0d", d), {txa[d], txb[d]}, 2'b01);
                        end
                        in_frame[d] = 1'b0;
                    end else if (in_frame[d] && !txa[d]) begin
                        check($sformatf("tx_active_until_done%0d", d), txa[d], 1);
                        in_frame[d] = 1'b0;
                    end
                    if (txa[d] && !in_frame[d]) begin
                        have = (d == 0) ? (txq0.size() > 0) : (txq1.size() > 0);
                        check($sformatf("tx_frame_expected%0d", d), have, 1);
                        if (have) begin
                            tw = (d == 0) ? txq0.pop_front() : txq1.pop_front();
                            build_frame(tw, d == 0, odd_parity(tw), 1'b1, tx_bits[d], tx_n[d]);
                            in_frame[d] = 1'b1;
                            tx_start[d] = cyc;
                        end
                    end
                    if (in_frame[d] && txa[d]) begin
                        off = cyc - tx_start[d];
                        if (off >= tx_n[d] * CPB) begin
                            check($sformatf("tx_within_frame%0d", d), off < tx_n[d] * CPB, 1);
                            in_frame[d] = 1'b0;
                        end else if (off % CPB == CPB / 2) begin
                            check($sformatf("tx_bit%0d_dut%0d", off / CPB, d), txb[d], tx_bits[d][off / CPB]);
                        end
                    end
                    if (rxa[d]) act_cycles[d]++;
                    if (rxv[d]) begin
                        have = (d == 0) ? (rxq0.size() > 0) : (rxq1.size() > 0);
                        check($sformatf("rx_valid_expected%0d", d), have, 1);
                        if (have) begin
                            e = (d == 0) ? rxq0.pop_front() : rxq1.pop_front();
                            check($sformatf("rx_data%0d", d), rxd[d], e.data);
                            check($sformatf("rx_par_error%0d", d), pe[d], e.pe);
                            check($sformatf("rx_stop_error%0d", d), se[d], e.se);
                            check($sformatf("rx_active_low_at_valid%0d", d), rxa[d], 0);
                        end
                        act_cycles[d] = 0;
                    end
                end
            end
            if (probe_req != probe_ack) begin
                if (probe_req == 1) begin
                    act_cycles[1] = 0;
                end else if (probe_req == 2) begin
                    check("glitch_rx_active_dropped", rxa[1], 0);
                    check("glitch_active_seen", (act_cycles[1] >= 1) && (act_cycles[1] <= CPB), 1);
                end else if (probe_req == 3) begin
                    check("rx_queue_drained", rxq0.size() + rxq1.size(), 0);
                    check("tx_queue_drained", txq0.size() + txq1.size(), 0);
                    check("tx_done_waits", tmo, 0);
                    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                    $finish;
                end
                probe_ack = probe_req;
            end
        end
    end

endmodule
